param_snn_core: RTL and testbench

PARAM_SNN_CORE -- requirements
Module: param_snn_core

---
 rtl/param_snn_core.sv | 184 ++++++++++++++++++
 tb/tb_param_snn_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_snn_core.sv
// param_snn_core: timestep-driven leaky integrate-and-fire core with refractory
// period and runtime-writable weights. Define SNN_WTA_EN for winner-take-all firing.
module param_snn_core #(
    parameter int INPUTNUM   = 4,
    parameter int EXCNUM     = 2,
    parameter int DW         = 16,
    parameter int WW         = 8,
    parameter int SW         = 12,
    parameter int THRESH     = 100,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC     = 2,
    localparam int NW        = INPUTNUM * EXCNUM,
    localparam int ADW       = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic [INPUTNUM*SW-1:0] sensor_in,
    input  logic [INPUTNUM*SW-1:0] in_thresh,
    input  logic                   w_we,
    input  logic [ADW-1:0]         w_addr,
    input  logic [WW-1:0]          w_data,
    output logic                   w_ready,
    output logic                   busy,
    output logic                   done,
    output logic [INPUTNUM-1:0]    pre_spike,
    output logic [EXCNUM-1:0]      Output_spike,
    output logic [1:0]             dbg_state,
    output logic [EXCNUM*DW-1:0]   dbg_v
);

    localparam int IW = (INPUTNUM > 1) ? $clog2(INPUTNUM) : 1;
    localparam int AW = WW + $clog2(INPUTNUM) + 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int XW = ((DW > AW) ? DW : AW) + 2;
    localparam logic signed [XW-1:0] VMAX = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0] VMIN = {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] THR_V = DW'(THRESH);

    // Handshake: a weight write commits on any enabled edge where w_we and
    // w_ready are both high; start is only taken while busy is low.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic signed [WW-1:0]  r_w    [NW];
    logic signed [AW-1:0]  r_acc  [EXCNUM];
    logic signed [DW-1:0]  r_v    [EXCNUM];
    logic [RW-1:0]         r_refr [EXCNUM];
    logic [INPUTNUM-1:0]   r_pre;
    logic [EXCNUM-1:0]     r_out;
    logic                  r_done;

    logic [INPUTNUM-1:0]   w_pre;
    logic signed [WW-1:0]  w_wsel [EXCNUM];
    logic signed [XW-1:0]  w_sum  [EXCNUM];
    logic signed [DW-1:0]  w_vsat [EXCNUM];
    logic [EXCNUM-1:0]     w_cross;
    logic [EXCNUM-1:0]     w_fire;
    logic                  w_wcommit;

    always_comb begin
        w_pre = '0;
        for (int i = 0; i < INPUTNUM; i++) begin
            w_pre[i] = (sensor_in[i*SW +: SW] >= in_thresh[i*SW +: SW]);
        end
    end

    // Membrane update is computed wide so the leak and accumulator sum can be
    // clamped instead of wrapping.
    always_comb begin
        w_cross = '0;
        for (int j = 0; j < EXCNUM; j++) begin
            w_wsel[j] = r_w[ADW'(int'(r_idx) * EXCNUM + j)];
            w_sum[j]  = XW'(r_v[j]) - XW'(r_v[j] >>> LEAK_SHIFT) + XW'(r_acc[j]);
            if (w_sum[j] > VMAX) begin
                w_vsat[j] = DW'(VMAX);
            end else if (w_sum[j] < VMIN) begin
                w_vsat[j] = DW'(VMIN);
            end else begin
                w_vsat[j] = DW'(w_sum[j]);
            end
            w_cross[j] = (r_refr[j] == '0) && (w_vsat[j] >= THR_V);
        end
`ifdef SNN_WTA_EN
        w_fire = w_cross & (~w_cross + EXCNUM'(1));
`else
        w_fire = w_cross;
`endif
    end

    assign w_wcommit = w_we && (r_state != S_ACCUM) && (int'(w_addr) < NW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pre   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                r_w[k] <= '0;
            end
            for (int j = 0; j < EXCNUM; j++) begin
                r_acc[j]  <= '0;
                r_v[j]    <= '0;
                r_refr[j] <= '0;
            end
        end else if (en) begin
            if (w_wcommit) begin
                r_w[w_addr] <= w_data;
            end
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pre <= w_pre;
                        r_idx <= '0;
                        for (int j = 0; j < EXCNUM; j++) begin
                            r_acc[j] <= '0;
                        end
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    for (int j = 0; j < EXCNUM; j++) begin
                        if (r_pre[r_idx]) begin
                            r_acc[j] <= r_acc[j] + AW'(w_wsel[j]);
                        end
                    end
                    if (r_idx == IW'(INPUTNUM - 1)) begin
                        r_idx   <= '0;
                        r_state <= S_UPDATE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_UPDATE: begin
                    // Losers of a winner-take-all round reset without a refractory period.
                    for (int j = 0; j < EXCNUM; j++) begin
                        if (r_refr[j] != '0) begin
                            r_v[j]    <= '0;
                            r_refr[j] <= r_refr[j] - RW'(1);
                            r_out[j]  <= 1'b0;
                        end else if (w_fire[j]) begin
                            r_v[j]    <= '0;
                            r_refr[j] <= RW'(REFRAC);
                            r_out[j]  <= 1'b1;
                        end else if (w_cross[j]) begin
                            r_v[j]    <= '0;
                            r_out[j]  <= 1'b0;
                        end else begin
                            r_v[j]    <= w_vsat[j];
                            r_out[j]  <= 1'b0;
                        end
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        dbg_v = '0;
        for (int j = 0; j < EXCNUM; j++) begin
            dbg_v[j*DW +: DW] = r_v[j];
        end
    end

    assign w_ready      = (r_state != S_ACCUM);
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign pre_spike    = r_pre;
    assign Output_spike = r_out;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_param_snn_core.sv
// Directed bench for param_snn_core: expected timestep results are queued by the
// driver and checked by a monitor on every done pulse.
module tb_param_snn_core;

    localparam int INPUTNUM = 4;
    localparam int EXCNUM   = 2;
    localparam int DW       = 10;   // narrow membrane so the negative clamp is reachable
    localparam int WW       = 8;
    localparam int SW       = 12;
    localparam int ADW      = 3;
    localparam int EW       = INPUTNUM + EXCNUM + EXCNUM * DW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   en = 1'b1;
    logic                   start = 1'b0;
    logic [INPUTNUM*SW-1:0] sensor_in = '0;
    logic [INPUTNUM*SW-1:0] in_thresh = '0;
    logic                   w_we = 1'b0;
    logic [ADW-1:0]         w_addr = '0;
    logic [WW-1:0]          w_data = '0;
    logic                   w_ready;
    logic                   busy;
    logic                   done;
    logic [INPUTNUM-1:0]    pre_spike;
    logic [EXCNUM-1:0]      Output_spike;
    logic [1:0]             dbg_state;
    logic [EXCNUM*DW-1:0]   dbg_v;

    int n_cmp = 0;
    int n_err = 0;
    int n_step = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] mon_act;

    param_snn_core #(
        .INPUTNUM(INPUTNUM), .EXCNUM(EXCNUM), .DW(DW), .WW(WW), .SW(SW),
        .THRESH(100), .LEAK_SHIFT(4), .REFRAC(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .sensor_in(sensor_in), .in_thresh(in_thresh),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .w_ready(w_ready), .busy(busy), .done(done),
        .pre_spike(pre_spike), .Output_spike(Output_spike),
        .dbg_state(dbg_state), .dbg_v(dbg_v)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [SW-1:0] thr(input int i);
        return SW'(100 + 7 * i);
    endfunction

    function automatic logic [EW-1:0] mk(input logic [3:0] pre, input logic [1:0] out,
                                         input int v0, input int v1);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = DW'(v0);
        b = DW'(v1);
        return {pre, out, b, a};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_w(input int addr, input int data);
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = ADW'(addr);
        w_data = WW'(data);
        @(negedge clk);
        w_we   = 1'b0;
    endtask

    task automatic set_sensors(input logic [3:0] mask);
        for (int i = 0; i < INPUTNUM; i++) begin
            sensor_in[i*SW +: SW] = mask[i] ? thr(i) : thr(i) - SW'(1);
        end
    endtask

    // wmode: write addr 3 during ACCUM (must be refused) and addr 1 = 40 in UPDATE.
    task automatic run_step(input logic [3:0] mask, input logic [EW-1:0] exp, input bit wmode);
        int cnt;
        @(negedge clk);
        set_sensors(mask);
        start = 1'b1;
        exp_q.push_back(exp);
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            start = 1'b0;
            if (cnt <= 6) begin
                check($sformatf("busy_c%0d", cnt), int'(busy), (cnt <= 5) ? 1 : 0);
                check($sformatf("w_ready_c%0d", cnt), int'(w_ready), (cnt >= 5) ? 1 : 0);
            end
            if (wmode) begin
                if (cnt <= 4) begin
                    w_we = 1'b1; w_addr = 3'd3; w_data = WW'(-100);
                end else if (cnt == 5) begin
                    w_we = 1'b1; w_addr = 3'd1; w_data = WW'(40);
                end else begin
                    w_we = 1'b0;
                end
            end
            if (done) break;
        end
        w_we = 1'b0;
        check("done_latency", cnt, 6);
    endtask

    always @(negedge clk) begin
        if (done) begin
            n_cmp++;
            n_step++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done step%0d: got done=1 expected no done", n_step);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_act = {pre_spike, Output_spike, dbg_v};
                if (mon_act !== mon_exp) begin
                    n_err++;
                    $display("FAIL step%0d result: got %h expected %h", n_step, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < INPUTNUM; i++) begin
            in_thresh[i*SW +: SW] = thr(i);
        end

        do_reset();
        check("rst_state", int'(dbg_state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_w_ready", int'(w_ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_out", int'(Output_spike), 0);
        check("rst_pre", int'(pre_spike), 0);
        check("rst_v", int'(dbg_v), 0);

        // Integrate, fire, two refractory steps, then integrate again.
        write_w(0, 60);
        run_step(4'b0001, mk(4'b0001, 2'b00, 60, 0), 1'b0);
        run_step(4'b0001, mk(4'b0001, 2'b01, 0, 0), 1'b0);
        run_step(4'b0001, mk(4'b0001, 2'b00, 0, 0), 1'b0);
        run_step(4'b0001, mk(4'b0001, 2'b00, 0, 0), 1'b0);
        run_step(4'b0001, mk(4'b0001, 2'b00, 60, 0), 1'b0);

        // Writes are refused during ACCUM; an UPDATE-cycle write lands for the next step.
        do_reset();
        run_step(4'b0001, mk(4'b0001, 2'b00, 0, 0), 1'b1);
        run_step(4'b0011, mk(4'b0011, 2'b00, 0, 40), 1'b0);

        // Reset in the middle of ACCUM aborts the step with no done.
        do_reset();
        write_w(0, 60);
        @(negedge clk);
        set_sensors(4'b0001);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_in_accum", int'(dbg_state), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", int'(dbg_state), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_v", int'(dbg_v), 0);
        check("abort_done", int'(done), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_step(4'b0001, mk(4'b0001, 2'b00, 0, 0), 1'b0);

        // Strongly negative drive clamps at the signed minimum instead of wrapping.
        do_reset();
        for (int a = 0; a < INPUTNUM * EXCNUM; a++) begin
            write_w(a, -128);
        end
        run_step(4'b1111, mk(4'b1111, 2'b00, -512, -512), 1'b0);
        run_step(4'b1111, mk(4'b1111, 2'b00, -512, -512), 1'b0);
        run_step(4'b1111, mk(4'b1111, 2'b00, -512, -512), 1'b0);

        // Two neurons crossing together.
        do_reset();
        write_w(0, 120);
        write_w(1, 120);
`ifdef SNN_WTA_EN
        run_step(4'b0001, mk(4'b0001, 2'b01, 0, 0), 1'b0);
        run_step(4'b0001, mk(4'b0001, 2'b10, 0, 0), 1'b0);
`else
        run_step(4'b0001, mk(4'b0001, 2'b11, 0, 0), 1'b0);
        run_step(4'b0001, mk(4'b0001, 2'b00, 0, 0), 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
